multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared ALU, register file, PC and unified memory of the multicycle MIPS core.
//  Decodes op/funct into per-state datapath strobes and the 3-bit ALUcontrol.
//  Supports a memory ready handshake and counts retired instructions.
//  Sits between the instruction register and the datapath muxes/enables.
// PARAMETERS
//  MEM_WAIT  1   1: memory states wait for mem_ready; 0: mem_ready ignored (mem_ok forced 1)
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  op          in   6      instr[31:26] from instruction register
//  funct       in   6      instr[5:0] from instruction register
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory access complete this cycle
//  IorD        out  1      0: address=PC, 1: address=ALUOut
//  MemWrite    out  1      memory write strobe
//  IRWrite     out  1      instruction register load
//  PCEn        out  1      PC load (PCWrite | (Branch & zero))
//  RegWrite    out  1      register file write
//  RegDst      out  1      0: rt, 1: rd
//  MemtoReg    out  1      0: ALUOut, 1: Data
//  ALUSrcA     out  1      0: PC, 1: A
//  ALUSrcB     out  2      00: B, 01: 4, 10: SignImm, 11: SignImm<<2
//  PCSrc       out  2      00: ALUResult, 01: ALUOut, 10: jump target
//  ALUcontrol  out  3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  state_o     out  4      current state (debug)
//  instr_done  out  1      one-cycle retire pulse
//  retired     out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: state=FETCH(0), retired=0. While reset is high, IRWrite/PCEn/RegWrite/MemWrite/instr_done are forced 0.
//  - Outputs are combinational from state (plus funct, zero, mem_ok). Any output not listed for a state is 0; ALUcontrol defaults to 010.
//  - mem_ok = mem_ready | (MEM_WAIT==0).
//  - Supported funct values: 100000 ADD (010), 100010 SUB (110), 100100 AND (000), 100101 OR (001), 101010 SLT (111).
//  - 0 FETCH: ALUSrcB=01, ALU add; IRWrite=PCEn=mem_ok. Next: DECODE if mem_ok, else FETCH.
//  - 1 DECODE: ALUSrcB=11, ALU add. Next state by op:
//      100011/101011 -> MEMADR
//      000000 -> EXECUTE if funct is supported, else FETCH
//      000100 -> BRANCH
//      001000 -> ADDIEX
//      000010 -> JUMP
//      any other op -> FETCH (treated as NOP)
//  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: MEMREAD if op=100011, else MEMWRITE.
//  - 3 MEMREAD: IorD=1. Next: MEMWB on mem_ok, else stay.
//  - 4 MEMWB: MemtoReg=1, RegWrite=1. Next: FETCH.
//  - 5 MEMWRITE: IorD=1, MemWrite=1, held until mem_ok. Next: FETCH on mem_ok.
//  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUcontrol=decode(funct). Next: ALUWB.
//  - 7 ALUWB: RegDst=1, RegWrite=1. Next: FETCH.
//  - 8 BRANCH: ALUSrcA=1, ALUcontrol=110, PCSrc=01, PCEn=zero. Next: FETCH.
//  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next: ADDIWB.
//  - 10 ADDIWB: RegWrite=1. Next: FETCH.
//  - 11 JUMP: PCSrc=10, PCEn=1. Next: FETCH.
//  - 12-15 illegal: all strobes 0. Next: FETCH. No retire.
//  - instr_done=1 in the last cycle of each instruction, i.e. any legal state whose next state is FETCH
//    (DECODE->FETCH NOP included; a MEMWRITE cycle only when mem_ok).
//    retired increments on that same edge.
//  - Cycles per instruction with mem_ok=1 throughout: beq/j 3; R-type/addi/sw 4; lw 5. Each mem_ready-low cycle adds 1.
// TESTING
//  - Reset during MEMREAD (state_o=3): state_o=0 asynchronously, strobes 0 while reset is high.
//    First cycle after release: IRWrite=1, PCEn=1.
//  - R-type add (op=0, funct=100000, mem_ready=1): state_o 0,1,6,7,0.
//    EXECUTE: ALUcontrol=010. ALUWB: RegWrite=1, RegDst=1, instr_done=1. retired 0->1.
//  - lw with mem_ready=0 for the first 3 MEMREAD cycles: state_o stays 3 for 4 cycles with IorD=1.
//    MEMWB then has MemtoReg=1; total 8 cycles.
//  - beq (op=000100): in BRANCH, zero=1 -> PCEn=1, PCSrc=01; zero=0 -> PCEn=0. Both return to FETCH.
//  - funct=101010 -> ALUcontrol=111 in EXECUTE.
//    funct=100111 -> DECODE->FETCH, RegWrite never 1, instr_done pulses once.
//  - CNT_W=4, MEM_WAIT=0: 17 back-to-back j instructions -> retired wraps 15->0->1.
//    mem_ready held 0 throughout with no stall.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core: sequences fetch/decode/execute,
// decodes funct into ALUcontrol, stalls on memory and counts retired instructions.
module multicycle_controller #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCEn,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUcontrol,
    output logic [3:0]       state_o,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    logic       mem_ok;
    logic       funct_ok;
    logic [2:0] funct_alu;

    assign mem_ok  = mem_ready | (MEM_WAIT == 0);
    assign state_o = state;

    // Unsupported R-type functs are retired as NOPs straight from DECODE.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        next_state = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUcontrol = 3'b010;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ok;
                PCEn       = mem_ok;
                next_state = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYP:      next_state = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
                instr_done = (next_state == FETCH);
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                IorD       = 1'b1;
                next_state = mem_ok ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ok;
                next_state = mem_ok ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = funct_alu;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = 3'b110;
                PCSrc      = 2'b01;
                PCEn       = zero;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
            end
            default: next_state = FETCH;
        endcase
        // FETCH is entered asynchronously, so its strobes must be suppressed during reset.
        if (reset) begin
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (instr_done) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle expectations are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_ready2 = 1'b0;

    logic        IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUcontrol;
    logic [3:0]  state_o;
    logic        instr_done;
    logic [31:0] retired;

    logic        IorD2, MemWrite2, IRWrite2, PCEn2, RegWrite2, RegDst2, MemtoReg2, ALUSrcA2;
    logic [1:0]  ALUSrcB2, PCSrc2;
    logic [2:0]  ALUcontrol2;
    logic [3:0]  state_o2;
    logic        instr_done2;
    logic [3:0]  retired2;

    typedef struct {
        bit          sel;
        string       name;
        logic [51:0] value;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010;
    localparam logic [5:0] F_BAD = 6'b100111;

    // strobe order: IorD MemWrite IRWrite PCEn RegWrite RegDst MemtoReg ALUSrcA
    localparam logic [7:0] S_NONE = 8'b0000_0000, S_FET = 8'b0011_0000, S_A = 8'b0000_0001;
    localparam logic [7:0] S_MRD = 8'b1000_0000, S_MWB = 8'b0000_1010, S_MWR = 8'b1100_0000;
    localparam logic [7:0] S_AWB = 8'b0000_1100, S_BRZ = 8'b0001_0001, S_IWB = 8'b0000_1000;
    localparam logic [7:0] S_JMP = 8'b0001_0000;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUcontrol(ALUcontrol), .state_o(state_o), .instr_done(instr_done),
        .retired(retired)
    );

    multicycle_controller #(.MEM_WAIT(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset2), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready2),
        .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCEn(PCEn2), .RegWrite(RegWrite2),
        .RegDst(RegDst2), .MemtoReg(MemtoReg2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .PCSrc(PCSrc2), .ALUcontrol(ALUcontrol2), .state_o(state_o2), .instr_done(instr_done2),
        .retired(retired2)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [51:0] act;
            e = q.pop_front();
            if (e.sel)
                act = {state_o2, IorD2, MemWrite2, IRWrite2, PCEn2, RegWrite2, RegDst2, MemtoReg2,
                       ALUSrcA2, ALUSrcB2, PCSrc2, ALUcontrol2, instr_done2, 28'd0, retired2};
            else
                act = {state_o, IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemtoReg,
                       ALUSrcA, ALUSrcB, PCSrc, ALUcontrol, instr_done, retired};
            checks++;
            if (act !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got st=%0d strb=%b srcB=%b pcsrc=%b alu=%b done=%b ret=%0d, expected st=%0d strb=%b srcB=%b pcsrc=%b alu=%b done=%b ret=%0d",
                         e.name, act[51:48], act[47:40], act[39:38], act[37:36], act[35:33], act[32], act[31:0],
                         e.value[51:48], e.value[47:40], e.value[39:38], e.value[37:36], e.value[35:33],
                         e.value[32], e.value[31:0]);
            end
        end
    end

    task automatic applyStimulus(input bit sel, input logic rst, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic mr, input string name, input logic [3:0] st,
                                 input logic [7:0] strb, input logic [1:0] sb, input logic [1:0] pc,
                                 input logic [2:0] alu, input logic dn, input logic [31:0] ret);
        exp_t e;
        op    = o;
        funct = f;
        zero  = z;
        if (sel) begin
            reset2     = rst;
            mem_ready2 = mr;
        end else begin
            reset     = rst;
            mem_ready = mr;
        end
        e.sel   = sel;
        e.name  = name;
        e.value = {st, strb, sb, pc, alu, dn, ret};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        applyStimulus(0, 1, OP_R, F_ADD, 0, 1, "reset_state", 0, S_NONE, 2'b01, 2'b00, 3'b010, 0, 0);
        // R-type add
        applyStimulus(0, 0, OP_R, F_ADD, 0, 1, "add_fetch",   0, S_FET,  2'b01, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_ADD, 0, 1, "add_decode",  1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_ADD, 0, 1, "add_exec",    6, S_A,    2'b00, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_ADD, 0, 1, "add_wb",      7, S_AWB,  2'b00, 2'b00, 3'b010, 1, 0);
        // lw with three stalled MEMREAD cycles
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "lw_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 1);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "lw_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 1);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "lw_memadr", 2, S_A,    2'b10, 2'b00, 3'b010, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, OP_LW, 0, 0, 0, "lw_memread_stall", 3, S_MRD, 2'b00, 2'b00, 3'b010, 0, 1);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "lw_memread_ok", 3, S_MRD, 2'b00, 2'b00, 3'b010, 0, 1);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "lw_memwb",      4, S_MWB, 2'b00, 2'b00, 3'b010, 1, 1);
        // beq taken and not taken
        applyStimulus(0, 0, OP_BEQ, 0, 1, 1, "beq1_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 2);
        applyStimulus(0, 0, OP_BEQ, 0, 1, 1, "beq1_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 2);
        applyStimulus(0, 0, OP_BEQ, 0, 1, 1, "beq1_branch", 8, S_BRZ,  2'b00, 2'b01, 3'b110, 1, 2);
        applyStimulus(0, 0, OP_BEQ, 0, 0, 1, "beq0_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 3);
        applyStimulus(0, 0, OP_BEQ, 0, 0, 1, "beq0_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 3);
        applyStimulus(0, 0, OP_BEQ, 0, 0, 1, "beq0_branch", 8, S_A,    2'b00, 2'b01, 3'b110, 1, 3);
        // slt
        applyStimulus(0, 0, OP_R, F_SLT, 0, 1, "slt_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 4);
        applyStimulus(0, 0, OP_R, F_SLT, 0, 1, "slt_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 4);
        applyStimulus(0, 0, OP_R, F_SLT, 0, 1, "slt_exec",   6, S_A,    2'b00, 2'b00, 3'b111, 0, 4);
        applyStimulus(0, 0, OP_R, F_SLT, 0, 1, "slt_wb",     7, S_AWB,  2'b00, 2'b00, 3'b010, 1, 4);
        // unsupported funct retires from DECODE
        applyStimulus(0, 0, OP_R, F_BAD, 0, 1, "badf_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 5);
        applyStimulus(0, 0, OP_R, F_BAD, 0, 1, "badf_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 1, 5);
        // sw with one stalled MEMWRITE cycle
        applyStimulus(0, 0, OP_SW, 0, 0, 1, "sw_fetch",       0, S_FET,  2'b01, 2'b00, 3'b010, 0, 6);
        applyStimulus(0, 0, OP_SW, 0, 0, 1, "sw_decode",      1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 6);
        applyStimulus(0, 0, OP_SW, 0, 0, 1, "sw_memadr",      2, S_A,    2'b10, 2'b00, 3'b010, 0, 6);
        applyStimulus(0, 0, OP_SW, 0, 0, 0, "sw_write_stall", 5, S_MWR,  2'b00, 2'b00, 3'b010, 0, 6);
        applyStimulus(0, 0, OP_SW, 0, 0, 1, "sw_write_ok",    5, S_MWR,  2'b00, 2'b00, 3'b010, 1, 6);
        // addi with a stalled fetch
        applyStimulus(0, 0, OP_ADDI, 0, 0, 0, "addi_fetch_stall", 0, S_NONE, 2'b01, 2'b00, 3'b010, 0, 7);
        applyStimulus(0, 0, OP_ADDI, 0, 0, 1, "addi_fetch",       0, S_FET,  2'b01, 2'b00, 3'b010, 0, 7);
        applyStimulus(0, 0, OP_ADDI, 0, 0, 1, "addi_decode",      1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 7);
        applyStimulus(0, 0, OP_ADDI, 0, 0, 1, "addi_ex",          9, S_A,    2'b10, 2'b00, 3'b010, 0, 7);
        applyStimulus(0, 0, OP_ADDI, 0, 0, 1, "addi_wb",         10, S_IWB,  2'b00, 2'b00, 3'b010, 1, 7);
        // jump, then an unknown opcode
        applyStimulus(0, 0, OP_J, 0, 0, 1, "j_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 8);
        applyStimulus(0, 0, OP_J, 0, 0, 1, "j_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 8);
        applyStimulus(0, 0, OP_J, 0, 0, 1, "j_jump",  11, S_JMP,  2'b00, 2'b10, 3'b010, 1, 8);
        applyStimulus(0, 0, 6'b111111, 0, 0, 1, "nop_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, 9);
        applyStimulus(0, 0, 6'b111111, 0, 0, 1, "nop_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 1, 9);
        // reset asserted while parked in MEMREAD
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "rlw_fetch",   0, S_FET,  2'b01, 2'b00, 3'b010, 0, 10);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "rlw_decode",  1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 10);
        applyStimulus(0, 0, OP_LW, 0, 0, 1, "rlw_memadr",  2, S_A,    2'b10, 2'b00, 3'b010, 0, 10);
        applyStimulus(0, 0, OP_LW, 0, 0, 0, "rlw_memread", 3, S_MRD,  2'b00, 2'b00, 3'b010, 0, 10);
        applyStimulus(0, 1, OP_LW, 0, 0, 1, "rlw_reset_a", 0, S_NONE, 2'b01, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 1, OP_LW, 0, 0, 1, "rlw_reset_b", 0, S_NONE, 2'b01, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_SUB, 0, 1, "post_reset_fetch", 0, S_FET,  2'b01, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_SUB, 0, 1, "sub_decode",       1, S_NONE, 2'b11, 2'b00, 3'b010, 0, 0);
        applyStimulus(0, 0, OP_R, F_SUB, 0, 1, "sub_exec",         6, S_A,    2'b00, 2'b00, 3'b110, 0, 0);
        applyStimulus(0, 0, OP_R, F_SUB, 0, 1, "sub_wb",           7, S_AWB,  2'b00, 2'b00, 3'b010, 1, 0);
        applyStimulus(0, 0, OP_R, F_SUB, 0, 1, "sub_retired",      0, S_FET,  2'b01, 2'b00, 3'b010, 0, 1);

        // Narrow counter, no memory wait: 17 jumps with mem_ready low wrap 15->0->1.
        applyStimulus(1, 1, OP_J, 0, 0, 0, "w_reset", 0, S_NONE, 2'b01, 2'b00, 3'b010, 0, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 0, OP_J, 0, 0, 0, "w_fetch",  0, S_FET,  2'b01, 2'b00, 3'b010, 0, i % 16);
            applyStimulus(1, 0, OP_J, 0, 0, 0, "w_decode", 1, S_NONE, 2'b11, 2'b00, 3'b010, 0, i % 16);
            applyStimulus(1, 0, OP_J, 0, 0, 0, "w_jump",  11, S_JMP,  2'b00, 2'b10, 3'b010, 1, i % 16);
        end
        applyStimulus(1, 0, OP_J, 0, 0, 0, "w_wrapped", 0, S_FET, 2'b01, 2'b00, 3'b010, 0, 1);

        @(negedge clk);
        #1;
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
